flr_csr_target: RTL and testbench
=================================

FLR_CSR_TARGET -- requirements
Module: flr_csr_target

Interface
REQ-001 SHALL have parameter FLR_DONE_ADDR, default 42'h819100017c: byte address of the FLR-done register.
REQ-002 SHALL have parameter NUM_PF, default 4: number of physical-function done bits.
REQ-003 SHALL have these ports, as name, direction, width, meaning:
- i_clk, in, 1: the single clock.
- i_reset, in, 1: synchronous, active-high reset.
REQ-004 SHALL have these AXI4 write-address ports:
- i_awaddr, in, 42: write address.
- i_awid, in, 8: write ID.
- i_awlen, in, 8: burst length minus one.
- i_awsize, in, 3: beat size.
- i_awburst, in, 2: burst type.
- i_awvalid, in, 1: address valid.
- o_awready, out, 1: address ready.
REQ-005 SHALL have these AXI4 write-data ports:
- i_wdata, in, 256: write data.
- i_wstrb, in, 32: byte-lane strobes.
- i_wlast, in, 1: last beat.
- i_wvalid, in, 1: data valid.
- o_wready, out, 1: data ready.
REQ-006 SHALL have these AXI4 write-response ports:
- o_bid, out, 8: response ID.
- o_bresp, out, 2: response code.
- o_bvalid, out, 1: response valid.
- i_bready, in, 1: response ready.
REQ-007 SHALL have these FLR ports:
- i_flr_clear, in, NUM_PF: per-PF clear when FLR starts.
- o_flr_pf_done, out, NUM_PF: registered done bits.
- o_flr_done_pulse, out, NUM_PF: one-cycle pulse on each 0->1 done transition.
- o_err, out, 1: sticky, set on any non-OKAY response.

Function
REQ-008 SHALL hold at most one transaction outstanding, using states IDLE, GOT_AW, GOT_W, DRAIN, RESP.
REQ-009 In IDLE, o_awready=1 and o_wready=1; AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-010 IDLE SHALL go to RESP when AW and a W with wlast are both accepted in the same cycle.
REQ-011 IDLE SHALL go to GOT_AW on AW only, and to GOT_W on a W with wlast only.
REQ-012 An accepted W beat without wlast SHALL move the block to DRAIN.
REQ-013 DRAIN SHALL keep o_wready=1 and discard beats until wlast, then go to RESP if AW has been captured, else to GOT_W.
REQ-014 GOT_AW SHALL drive o_awready=0 and o_wready=1; GOT_W SHALL drive o_awready=1 and o_wready=0.
REQ-015 o_bvalid SHALL rise the cycle after the final handshake of the transaction, with o_bid equal to the captured awid.
REQ-016 In RESP, o_awready=o_wready=0, and o_bvalid, o_bid and o_bresp SHALL hold stable until i_bready; then o_bvalid=0 and the state returns to IDLE.
REQ-017 o_bresp SHALL be DECERR (2'b11) when awaddr differs from FLR_DONE_ADDR.
REQ-018 Otherwise o_bresp SHALL be SLVERR (2'b10) when awlen is not 0 or awburst is FIXED (2'b00).
REQ-019 Otherwise o_bresp SHALL be OKAY (2'b00).
REQ-020 Only an OKAY write with wstrb[28]=1 SHALL update the register: o_flr_pf_done <= wdata[224 +: NUM_PF].
REQ-021 An OKAY write with wstrb[28]=0 SHALL leave the register unchanged.
REQ-022 In every cycle with no register update, done bits SHALL clear where i_flr_clear=1.
REQ-023 When a register update and i_flr_clear hit the same cycle, the written value SHALL win.
REQ-024 o_flr_done_pulse[i] SHALL be high for exactly the one cycle after o_flr_pf_done[i] goes 0->1.
REQ-025 o_err SHALL set on the first cycle o_bvalid is high with o_bresp != OKAY, and stay set until reset.

Reset
REQ-026 While i_reset=1, the state SHALL be IDLE.
REQ-027 While i_reset=1, o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_flr_pf_done, o_flr_done_pulse and o_err SHALL all be 0.
REQ-028 Reset asserted mid-transaction SHALL discard all captured AW/W state, and o_bvalid SHALL drop in the next cycle.
REQ-029 Ready outputs SHALL rise in the first cycle after reset is released.

Structure
REQ-030 A shared package SHALL hold the state enum and the BRESP constants OKAY, SLVERR and DECERR.
REQ-031 FLR_DONE_ADDR SHALL be a module parameter, not a package constant.
REQ-032 There SHALL be one sub-module, flr_done_reg, containing the done register, clear/write priority and edge-pulse logic.

Verification
REQ-033 Bench SHALL cover a same-cycle write:
- Stimulus: AW(addr 0x819100017c, awid 2, awlen 0, awburst INCR) and W(wdata[227:224]=4'b0101, wstrb 0xf0000000, wlast) together.
- Response: next cycle bvalid=1, bid=2, bresp=OKAY; o_flr_pf_done=4'b0101; done pulse on bits 0 and 2 for one cycle.
REQ-034 Bench SHALL cover W before AW: W arrives 3 cycles before AW -> bvalid exactly 1 cycle after the AW handshake; bready held low for 5 cycles -> bvalid, bid and bresp stable throughout.
REQ-035 Bench SHALL cover a bad address: awaddr 0x8191000180 -> bresp=DECERR, register unchanged, o_err=1.
REQ-036 Bench SHALL cover a burst write: awlen=3 with 4 W beats -> all beats accepted, single response with bresp=SLVERR, register unchanged.
REQ-037 Bench SHALL cover a clear/write collision: i_flr_clear=4'b1111 in the same cycle as an OKAY write of 4'b0011 -> register=4'b0011; clear=4'b0001 the next cycle -> register=4'b0010.
REQ-038 Bench SHALL cover reset in GOT_AW: i_reset pulsed -> all outputs 0; a following complete write is handled normally.

Source files
------------

// File: rtl/flr_csr_target_pkg.sv
// Shared types and constants for the FLR-done CSR write target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flr_csr_target_pkg;

    // Write-channel state: at most one transaction in flight.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_AW = 3'd1,
        GOT_W  = 3'd2,
        DRAIN  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // AXI write-response codes.
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // AXI burst encoding that this target refuses.
    localparam logic [1:0] BURST_FIXED = 2'b00;

    // Location of the done bits inside the 256-bit data beat.
    localparam int DONE_STRB_BIT = 28;
    localparam int DONE_DATA_LSB = 224;

    // Response code for a captured write address.
    function automatic logic [1:0] decode_resp(input logic addr_hit,
                                               input logic [7:0] awlen,
                                               input logic [1:0] awburst);
        logic [1:0] resp;
        resp = OKAY;
        if (!addr_hit) begin
            resp = DECERR;
        end else if ((awlen != 8'd0) || (awburst == BURST_FIXED)) begin
            resp = SLVERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/flr_done_reg.sv
// Per-PF FLR done register with clear/write priority and rising-edge pulses.
// Latency: write or clear visible one cycle after the update; pulse in that same cycle.
// Backpressure: none, updates and clears are accepted every cycle.
module flr_done_reg #(
    parameter int NUM_PF = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_upd_vld,
    input  logic [NUM_PF-1:0] i_upd_dat,
    input  logic [NUM_PF-1:0] i_clear,
    output logic [NUM_PF-1:0] o_done,
    output logic [NUM_PF-1:0] o_pulse
);

    logic [NUM_PF-1:0] done_d, done_q;
    logic [NUM_PF-1:0] pulse_d, pulse_q;

    // A write overrides a same-cycle clear; otherwise clears knock bits down.
    always_comb begin
        done_d  = i_upd_vld ? i_upd_dat : (done_q & ~i_clear);
        pulse_d = done_d & ~done_q;
    end

    // Register done bits and their 0->1 edge pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            done_q  <= '0;
            pulse_q <= '0;
        end else begin
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_done  = done_q;
    assign o_pulse = pulse_q;

endmodule

// File: rtl/flr_csr_target.sv
// AXI4 write-only target for the FLR-done CSR; one transaction outstanding.
// Latency: bvalid and register update one cycle after the last AW/W handshake.
// Backpressure: ready deasserted per channel once captured; response held until bready.
module flr_csr_target
    import flr_csr_target_pkg::*;
#(
    parameter logic [41:0] FLR_DONE_ADDR = 42'h819100017c,
    parameter int          NUM_PF        = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [41:0]       i_awaddr,
    input  logic [7:0]        i_awid,
    input  logic [7:0]        i_awlen,
    input  logic [2:0]        i_awsize,
    input  logic [1:0]        i_awburst,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [255:0]      i_wdata,
    input  logic [31:0]       i_wstrb,
    input  logic              i_wlast,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [7:0]        o_bid,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [NUM_PF-1:0] i_flr_clear,
    output logic [NUM_PF-1:0] o_flr_pf_done,
    output logic [NUM_PF-1:0] o_flr_done_pulse,
    output logic              o_err
);

    state_t            state_d, state_q;
    logic              awready_d, awready_q;
    logic              wready_d, wready_q;
    logic              bvalid_d, bvalid_q;
    logic              aw_got_d, aw_got_q;
    logic              w_got_d, w_got_q;
    logic [7:0]        awid_d, awid_q;
    logic [1:0]        resp_d, resp_q;
    logic [NUM_PF-1:0] dat_d, dat_q;
    logic              strb_d, strb_q;
    logic              err_d, err_q;
    logic              aw_hs, w_hs, upd_vld;
    logic              unused_ok;

    // Only the done slice and one strobe matter; awsize is accepted but ignored.
    assign unused_ok = ^{i_awsize, i_wdata, i_wstrb};

    // Next-state, capture and registered-output computation for the write FSM.
    always_comb begin
        aw_hs     = i_awvalid & awready_q;
        w_hs      = i_wvalid & wready_q;
        state_d   = state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awid_d    = awid_q;
        resp_d    = resp_q;
        dat_d     = dat_q;
        strb_d    = strb_q;

        if (aw_hs) begin
            aw_got_d = 1'b1;
            awid_d   = i_awid;
            resp_d   = decode_resp(i_awaddr == FLR_DONE_ADDR, i_awlen, i_awburst);
        end
        // Only the first beat carries data; later burst beats are discarded.
        if (w_hs && !w_got_q) begin
            w_got_d = 1'b1;
            dat_d   = i_wdata[DONE_DATA_LSB +: NUM_PF];
            strb_d  = i_wstrb[DONE_STRB_BIT];
        end

        case (state_q)
            IDLE: begin
                if (w_hs && !i_wlast)  state_d = DRAIN;
                else if (aw_hs && w_hs) state_d = RESP;
                else if (aw_hs)         state_d = GOT_AW;
                else if (w_hs)          state_d = GOT_W;
            end
            GOT_AW: begin
                if (w_hs) state_d = i_wlast ? RESP : DRAIN;
            end
            GOT_W: begin
                if (aw_hs) state_d = RESP;
            end
            DRAIN: begin
                if (w_hs && i_wlast) state_d = aw_got_d ? RESP : GOT_W;
            end
            RESP: begin
                if (i_bready) begin
                    state_d  = IDLE;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // AW is still accepted while draining a burst that arrived first.
        awready_d = (state_d == IDLE) || (state_d == GOT_W) ||
                    ((state_d == DRAIN) && !aw_got_d);
        wready_d  = (state_d == IDLE) || (state_d == GOT_AW) || (state_d == DRAIN);
        bvalid_d  = (state_d == RESP);
        upd_vld   = (state_d == RESP) && (state_q != RESP) &&
                    (resp_d == OKAY) && strb_d;
        err_d     = err_q | (bvalid_d && (resp_d != OKAY));

        if (i_reset) begin
            state_d   = IDLE;
            aw_got_d  = 1'b0;
            w_got_d   = 1'b0;
            awid_d    = '0;
            resp_d    = OKAY;
            dat_d     = '0;
            strb_d    = 1'b0;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b0;
            upd_vld   = 1'b0;
            err_d     = 1'b0;
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge i_clk) begin
        state_q   <= state_d;
        aw_got_q  <= aw_got_d;
        w_got_q   <= w_got_d;
        awid_q    <= awid_d;
        resp_q    <= resp_d;
        dat_q     <= dat_d;
        strb_q    <= strb_d;
        awready_q <= awready_d;
        wready_q  <= wready_d;
        bvalid_q  <= bvalid_d;
        err_q     <= err_d;
    end

    flr_done_reg #(
        .NUM_PF (NUM_PF)
    ) u_done (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_upd_vld (upd_vld),
        .i_upd_dat (dat_d),
        .i_clear   (i_flr_clear),
        .o_done    (o_flr_pf_done),
        .o_pulse   (o_flr_done_pulse)
    );

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bid     = awid_q;
    assign o_bresp   = resp_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_flr_csr_target.sv
// Directed bench for flr_csr_target with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Summary line reports passed/total checks.
module tb_flr_csr_target;

    logic         clk = 1'b0;
    logic         rst;
    logic [41:0]  awaddr;
    logic [7:0]   awid, awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [3:0]   flr_clear, pf_done, done_pulse;
    logic         err;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [41:0] GOOD_ADDR = 42'h819100017c;
    localparam logic [41:0] BAD_ADDR  = 42'h8191000180;

    always #5 clk = ~clk;

    flr_csr_target dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_awaddr         (awaddr),
        .i_awid           (awid),
        .i_awlen          (awlen),
        .i_awsize         (awsize),
        .i_awburst        (awburst),
        .i_awvalid        (awvalid),
        .o_awready        (awready),
        .i_wdata          (wdata),
        .i_wstrb          (wstrb),
        .i_wlast          (wlast),
        .i_wvalid         (wvalid),
        .o_wready         (wready),
        .o_bid            (bid),
        .o_bresp          (bresp),
        .o_bvalid         (bvalid),
        .i_bready         (bready),
        .i_flr_clear      (flr_clear),
        .o_flr_pf_done    (pf_done),
        .o_flr_done_pulse (done_pulse),
        .o_err            (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_aw(input logic [41:0] a, input logic [7:0] id,
                          input logic [7:0] len, input logic [1:0] burst);
        awaddr  = a;
        awid    = id;
        awlen   = len;
        awburst = burst;
        awsize  = 3'd5;
        awvalid = 1'b1;
    endtask

    task automatic set_w(input logic [3:0] val, input logic [31:0] strb, input logic last);
        logic [255:0] d;
        d            = '0;
        d[224 +: 4]  = val;
        wdata        = d;
        wstrb        = strb;
        wlast        = last;
        wvalid       = 1'b1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_awready"}, awready, 0);
        chk({pfx, "_wready"},  wready, 0);
        chk({pfx, "_bvalid"},  bvalid, 0);
        chk({pfx, "_bid"},     bid, 0);
        chk({pfx, "_bresp"},   bresp, 0);
        chk({pfx, "_done"},    pf_done, 0);
        chk({pfx, "_pulse"},   done_pulse, 0);
        chk({pfx, "_err"},     err, 0);
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; flr_clear = '0;

        // Reset state
        step(); step(); step();
        chk_all_zero("rst");
        rst = 1'b0;
        step();
        chk("rel_awready", awready, 1);
        chk("rel_wready",  wready, 1);

        // Same-cycle AW + W, OKAY write of 0101
        set_aw(GOOD_ADDR, 8'd2, 8'd0, 2'b01);
        set_w(4'b0101, 32'hf000_0000, 1'b1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("sc_bvalid", bvalid, 1);
        chk("sc_bid",    bid, 2);
        chk("sc_bresp",  bresp, 2'b00);
        chk("sc_done",   pf_done, 4'b0101);
        chk("sc_pulse",  done_pulse, 4'b0101);
        chk("sc_awready_resp", awready, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("sc_bvalid_drop", bvalid, 0);
        chk("sc_pulse_drop",  done_pulse, 0);
        chk("sc_done_hold",   pf_done, 4'b0101);

        // W three cycles ahead of AW, then bready withheld for 5 cycles
        set_w(4'b1010, 32'h1000_0000, 1'b1);
        step();
        wvalid = 1'b0;
        chk("wa_wready_gotw",  wready, 0);
        chk("wa_awready_gotw", awready, 1);
        chk("wa_no_bvalid",    bvalid, 0);
        step(); step();
        set_aw(GOOD_ADDR, 8'd5, 8'd0, 2'b01);
        step();
        awvalid = 1'b0;
        chk("wa_bvalid", bvalid, 1);
        chk("wa_done",   pf_done, 4'b1010);
        chk("wa_pulse",  done_pulse, 4'b1010);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wa_hold_bvalid", bvalid, 1);
            chk("wa_hold_bid",    bid, 5);
            chk("wa_hold_bresp",  bresp, 2'b00);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("wa_bvalid_drop", bvalid, 0);

        // Bad address: DECERR, register untouched, sticky error
        set_aw(BAD_ADDR, 8'd7, 8'd0, 2'b01);
        set_w(4'b1111, 32'hf000_0000, 1'b1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("da_bvalid", bvalid, 1);
        chk("da_bresp",  bresp, 2'b11);
        chk("da_done",   pf_done, 4'b1010);
        chk("da_err",    err, 1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("da_err_sticky", err, 1);

        // Four-beat burst: SLVERR, every beat accepted
        set_aw(GOOD_ADDR, 8'd9, 8'd3, 2'b01);
        set_w(4'b0000, 32'hf000_0000, 1'b0);
        step();
        awvalid = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            chk("bu_wready", wready, 1);
            chk("bu_no_bvalid", bvalid, 0);
            set_w(4'b0000, 32'hf000_0000, (b == 3));
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bu_bvalid", bvalid, 1);
        chk("bu_bid",    bid, 9);
        chk("bu_bresp",  bresp, 2'b10);
        chk("bu_done",   pf_done, 4'b1010);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bu_bvalid_drop", bvalid, 0);

        // Clear collides with an OKAY write; write wins, then clear acts
        set_aw(GOOD_ADDR, 8'd1, 8'd0, 2'b01);
        set_w(4'b0011, 32'h1000_0000, 1'b1);
        flr_clear = 4'b1111;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("cc_done_write_wins", pf_done, 4'b0011);
        chk("cc_pulse",           done_pulse, 4'b0001);
        flr_clear = 4'b0001;
        bready    = 1'b1;
        step();
        flr_clear = 4'b0000;
        bready    = 1'b0;
        chk("cc_done_cleared", pf_done, 4'b0010);
        chk("cc_pulse_drop",   done_pulse, 0);

        // Reset while holding an AW, then a normal write
        set_aw(GOOD_ADDR, 8'd3, 8'd0, 2'b01);
        step();
        awvalid = 1'b0;
        chk("ra_awready_gotaw", awready, 0);
        chk("ra_wready_gotaw",  wready, 1);
        rst = 1'b1;
        step();
        chk_all_zero("ra");
        rst = 1'b0;
        step();
        chk("ra_awready_rel", awready, 1);
        chk("ra_bvalid_none", bvalid, 0);
        set_aw(GOOD_ADDR, 8'd4, 8'd0, 2'b01);
        set_w(4'b0110, 32'hf000_0000, 1'b1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("ra_bvalid", bvalid, 1);
        chk("ra_bid",    bid, 4);
        chk("ra_bresp",  bresp, 2'b00);
        chk("ra_done",   pf_done, 4'b0110);
        chk("ra_pulse",  done_pulse, 4'b0110);
        chk("ra_err",    err, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("ra_bvalid_drop", bvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
